seg_mux_driver: RTL and testbench
=================================

# seg_mux_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display. It accepts a packed hex value plus per-digit blanking and scans one digit at a time at a programmable refresh rate, decoding each nibble to active-low segment patterns. Input updates are double-buffered so a value change never shows up mid-frame. It sits between the anti-theft control logic (status/code values) and the board display pins, and supersedes the single-digit, fixed-anode combinational decoder.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 100000, clock cycles each digit is held (>=1)
- LZ_BLANK, 0, 1 = blank leading zero digits (digit 0 never blanked by this rule)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- value  in  4*NUM_DIGITS  hex nibbles; nibble i = value[4i+3:4i] drives digit i (digit 0 rightmost)
- blank_mask  in  NUM_DIGITS  1 = force digit i dark
- load  in  1  one-cycle strobe; captures value/blank_mask (and dp_in) into pending buffer
- dp_in  in  NUM_DIGITS  decimal point request per digit (present only with SEG_MUX_DP_EN)
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low while scanning
- segments  out  7  cathodes a..g on bits 0..6, active-low
- dp_n  out  1  decimal point cathode, active-low (tied 1 without SEG_MUX_DP_EN)
- frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0

## Operation
- Prescaler counts 0..REFRESH_DIV-1; `tick` is asserted when the count equals REFRESH_DIV-1, and the count then returns to 0.
- Digit index idx (width clog2(NUM_DIGITS), min 1) advances on tick; it wraps from NUM_DIGITS-1 to 0. The wrap is the frame boundary.
- Pending buffer: written on any cycle with load=1.
- Active buffer: copied from pending at the frame boundary only.
- If load and the frame boundary coincide, the newly loaded data goes directly into active and pending.
- Decode of nibble: standard hex glyphs 0-F. Bit patterns are a=bit0..g=bit6 before inversion. Examples: 0=0111111, 1=0000110, 8=1111111, A=1110111, F=1110001.
- Digit i is dark when any of the following holds:
  - blank_mask[i]=1;
  - LZ_BLANK=1, i>0, and nibble i and all higher nibbles are 0.
- A dark digit still has its anode driven low, with segments=7'h7F and dp_n=1. This keeps scan duty uniform.
- Outputs for the digit at index idx:
  - an = ~(1<<idx);
  - segments = ~pattern, or 7'h7F when dark;
  - dp_n = ~dp_active[idx], forced to 1 when dark.
- There is no handshake back-pressure; load is always accepted.

## Timing
- Reset values: prescaler 0, idx 0, pending/active buffers 0, an all-1, segments 7'h7F, dp_n 1, frame_done 0.
- an, segments, dp_n and frame_done are all registered outputs.
- First cycle after reset release: outputs show digit 0 of the active buffer (zeros) with an[0]=0. This value is therefore "0" on digit 0 unless it is blanked.
- Output latency: outputs change in the clock cycle after tick (one-cycle register latency). Each digit is held for exactly REFRESH_DIV cycles.
- frame_done is high for the single cycle in which the outputs first show digit 0 of a new frame.
- REFRESH_DIV=1: the digit advances every cycle and frame_done pulses every NUM_DIGITS cycles.
- NUM_DIGITS=1: idx stays 0, frame_done pulses every REFRESH_DIV cycles, and active updates at that rate.
- Asserting rst mid-frame immediately forces the reset values (asynchronous). Pending data is lost.

## Configuration
- SEG_MUX_DP_EN defined:
  - the dp_in port exists;
  - dp_in is buffered pending/active like value;
  - dp_n is driven per digit.
- SEG_MUX_DP_EN undefined:
  - no dp_in port and no dp buffer registers;
  - dp_n is constant 1.

## Structure
- Package seg_pkg holds:
  - localparams SEG_OFF=7'h7F;
  - the 16-entry glyph constant array indexed by nibble;
  - the function clog2_min1.
- Sub-module seg_hex_decode is a combinational nibble-to-active-low-pattern decoder using the seg_pkg glyph array. It is instantiated once, on the muxed nibble.
- Top-level contents: prescaler, index counter, pending/active buffers, leading-zero logic, output registers.

## Test plan
- Reset, NUM_DIGITS=4, REFRESH_DIV=4, no load:
  - an cycles 1110, 1101, 1011, 0111, each held 4 cycles;
  - segments=~0111111 on every digit;
  - frame_done pulses every 16 cycles.
- Load value=16'h12AF mid-frame:
  - digits keep the old value until the next frame_done;
  - then digit0..3 show F, A, 2, 1 (segments ~1110001, ~1110111, ~1011011, ~0000110).
- LZ_BLANK=1, value=16'h0040:
  - digits 3 and 2 dark (7'h7F), digit 1 = "4", digit 0 = "0";
  - an still scans all four digits.
- load asserted on the same cycle as the frame wrap with value=16'h8888: the very next frame shows all digits as 8 (segments 7'h00).
- With SEG_MUX_DP_EN, dp_in=4'b0100 and blank_mask=4'b0100: dp_n=0 only when an=1011 would be active, but digit 2 is blanked, so dp_n stays 1 for the whole frame.
- rst pulsed while idx=2:
  - an=all-1, segments=7'h7F and frame_done=0 immediately;
  - after release, scan restarts at digit 0 with the zero value.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment driver: blank pattern, hex glyph table, index-width helper.
// Glyph bits are a..g on bits 0..6, active-high here; decoders invert for the common-anode pins.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low seven-segment pattern (a..g on bits 0..6).
// Latency: combinational. Backpressure: none.
// Single instance in the driver, fed by the digit mux.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = ~GLYPH[nibble];

endmodule

// File: rtl/seg_mux_driver.sv
// Time-multiplexed common-anode N-digit driver, double-buffered value/blank (dp too with SEG_MUX_DP_EN).
// Latency: registered outputs change one cycle after the prescaler tick; active buffer swaps at frame wrap.
// Backpressure: none, load is accepted on every cycle.
module seg_mux_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int LZ_BLANK    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic                      load,
`ifdef SEG_MUX_DP_EN
    input  logic [NUM_DIGITS-1:0]     dp_in,
`endif
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                segments,
    output logic                      dp_n,
    output logic                      frame_done
);

    localparam int IW = clog2_min1(NUM_DIGITS);
    localparam int CW = clog2_min1(REFRESH_DIV);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0]             cnt;
    logic [IW-1:0]             idx;
    logic [IW-1:0]             idx_nxt;
    logic                      tick;
    logic                      wrap;
    logic [4*NUM_DIGITS-1:0]   pend_val;
    logic [4*NUM_DIGITS-1:0]   act_val;
    logic [4*NUM_DIGITS-1:0]   act_val_nxt;
    logic [NUM_DIGITS-1:0]     pend_blank;
    logic [NUM_DIGITS-1:0]     act_blank;
    logic [NUM_DIGITS-1:0]     act_blank_nxt;
    logic [NUM_DIGITS-1:0]     lz_dark;
    logic [NUM_DIGITS-1:0]     an_nxt;
    logic                      upper_zero;
    logic                      dark;
    logic [3:0]                nib;
    logic [6:0]                glyph_n;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_comb begin
        idx_nxt = idx;
        if (tick) begin
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
    end

    // A load on the wrap cycle bypasses pending so the new frame already shows it.
    assign act_val_nxt   = wrap ? (load ? value : pend_val) : act_val;
    assign act_blank_nxt = wrap ? (load ? blank_mask : pend_blank) : act_blank;

    always_comb begin
        upper_zero = 1'b1;
        lz_dark    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (act_val_nxt[4*i +: 4] == 4'h0);
            lz_dark[i] = (LZ_BLANK != 0) && (i > 0) && upper_zero;
        end
    end

`ifdef SEG_MUX_DP_EN
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [NUM_DIGITS-1:0] act_dp;
    logic [NUM_DIGITS-1:0] act_dp_nxt;
    logic                  dp_sel;

    assign act_dp_nxt = wrap ? (load ? dp_in : pend_dp) : act_dp;
`endif

    always_comb begin
        nib  = 4'h0;
        dark = 1'b0;
`ifdef SEG_MUX_DP_EN
        dp_sel = 1'b0;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IW'(i)) begin
                nib  = act_val_nxt[4*i +: 4];
                dark = act_blank_nxt[i] | lz_dark[i];
`ifdef SEG_MUX_DP_EN
                dp_sel = act_dp_nxt[i];
`endif
            end
        end
    end

    assign an_nxt = ~(NUM_DIGITS'(1) << idx_nxt);

    seg_hex_decode u_dec (
        .nibble (nib),
        .seg_n  (glyph_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_blank <= '0;
            act_val    <= '0;
            act_blank  <= '0;
            an         <= '1;
            segments   <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + CW'(1);
            idx        <= idx_nxt;
            if (load) begin
                pend_val   <= value;
                pend_blank <= blank_mask;
            end
            act_val    <= act_val_nxt;
            act_blank  <= act_blank_nxt;
            an         <= an_nxt;
            segments   <= dark ? SEG_OFF : glyph_n;
            frame_done <= wrap;
        end
    end

`ifdef SEG_MUX_DP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_dp <= '0;
            act_dp  <= '0;
            dp_n    <= 1'b1;
        end else begin
            if (load) begin
                pend_dp <= dp_in;
            end
            act_dp <= act_dp_nxt;
            dp_n   <= dark | ~dp_sel;
        end
    end
`else
    assign dp_n = 1'b1;
`endif

endmodule

// File: tb/tb_seg_mux_driver.sv
// Bench for seg_mux_driver: three configurations share stimulus and are checked against a frame-level model.
module tb_seg_mux_driver;

`ifdef SEG_MUX_DP_EN
    localparam bit DPEN = 1'b1;
`else
    localparam bit DPEN = 1'b0;
`endif

    localparam int NN [3] = '{4, 4, 2};
    localparam int DD [3] = '{4, 4, 1};
    localparam int LL [3] = '{0, 1, 1};
    localparam logic [6:0] GL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] val = '0;
    logic [3:0]  blk = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  an_a, an_b;
    logic [1:0]  an_c;
    logic [6:0]  seg_a, seg_b, seg_c;
    logic        dpn_a, dpn_b, dpn_c, fd_a, fd_b, fd_c;
    logic [12:0] act [3];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    seg_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(0)) u_a (
        .clk(clk), .rst(rst), .value(val), .blank_mask(blk), .load(load),
`ifdef SEG_MUX_DP_EN
        .dp_in(dp),
`endif
        .an(an_a), .segments(seg_a), .dp_n(dpn_a), .frame_done(fd_a)
    );

    seg_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(1)) u_b (
        .clk(clk), .rst(rst), .value(val), .blank_mask(blk), .load(load),
`ifdef SEG_MUX_DP_EN
        .dp_in(dp),
`endif
        .an(an_b), .segments(seg_b), .dp_n(dpn_b), .frame_done(fd_b)
    );

    seg_mux_driver #(.NUM_DIGITS(2), .REFRESH_DIV(1), .LZ_BLANK(1)) u_c (
        .clk(clk), .rst(rst), .value(val[7:0]), .blank_mask(blk[1:0]), .load(load),
`ifdef SEG_MUX_DP_EN
        .dp_in(dp[1:0]),
`endif
        .an(an_c), .segments(seg_c), .dp_n(dpn_c), .frame_done(fd_c)
    );

    assign act[0] = {an_a, seg_a, dpn_a, fd_a};
    assign act[1] = {an_b, seg_b, dpn_b, fd_b};
    assign act[2] = {2'b00, an_c, seg_c, dpn_c, fd_c};

    // Model: m_e counts clock edges since reset release; digit shown = (m_e / DIV) mod N.
    int          m_e;
    logic [15:0] pv [3];
    logic [15:0] av [3];
    logic [3:0]  pb [3];
    logic [3:0]  ab [3];
    logic [3:0]  pd [3];
    logic [3:0]  ad [3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_e <= 0;
            for (int k = 0; k < 3; k++) begin
                pv[k] <= '0; av[k] <= '0; pb[k] <= '0; ab[k] <= '0; pd[k] <= '0; ad[k] <= '0;
            end
        end else begin
            m_e <= m_e + 1;
            for (int k = 0; k < 3; k++) begin
                logic [15:0] vm;
                logic [3:0]  bm;
                vm = 16'((32'd1 << (4 * NN[k])) - 1);
                bm = 4'((1 << NN[k]) - 1);
                if ((m_e + 1) % (DD[k] * NN[k]) == 0) begin
                    av[k] <= load ? (val & vm) : pv[k];
                    ab[k] <= load ? (blk & bm) : pb[k];
                    ad[k] <= load ? (dp & bm) : pd[k];
                end
                if (load) begin
                    pv[k] <= val & vm;
                    pb[k] <= blk & bm;
                    pd[k] <= dp & bm;
                end
            end
        end
    end

    function automatic logic [12:0] exp_out(input int k, input int e);
        int         n;
        int         dv;
        int         dg;
        logic       dark;
        logic [3:0] an;
        logic [3:0] nib;
        logic [6:0] sg;
        logic       dpn;
        logic       fd;
        n  = NN[k];
        dv = DD[k];
        if (e == 0) begin
            an = 4'((1 << n) - 1); sg = 7'h7F; dpn = 1'b1; fd = 1'b0;
        end else begin
            dg   = (e / dv) % n;
            an   = 4'(((1 << n) - 1) & ~(1 << dg));
            nib  = av[k][4*dg +: 4];
            dark = ab[k][dg] || (LL[k] != 0 && dg > 0 && (av[k] >> (4 * dg)) == 16'h0);
            sg   = dark ? 7'h7F : ~GL[nib];
            dpn  = (DPEN && !dark) ? ~ad[k][dg] : 1'b1;
            fd   = (e % (dv * n) == 0);
        end
        return {an, sg, dpn, fd};
    endfunction

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; val = '0; blk = '0; dp = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act[k] !== exp_out(k, 0))
                $display("FAIL reset k=%0d got=%h want=%h", k, act[k], exp_out(k, 0));
            if (act[k] !== exp_out(k, 0)) errors++;
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int pulses = 0;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            if (fd_a) pulses++;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== exp_out(k, m_e)) begin
                    errors++;
                    $display("FAIL scan k=%0d e=%0d got=%h want=%h", k, m_e, act[k], exp_out(k, m_e));
                end
            end
        end
        checks++;
        if (pulses !== 3) begin
            errors++;
            $display("FAIL scan_frames got=%0d want=3", pulses);
        end
    endtask

    task automatic test_load_mid();
        bit seen = 1'b0;
        int guard = 0;
        while (m_e % 16 != 6 && guard < 32) begin @(negedge clk); guard++; end
        load = 1'b1; val = 16'h12AF; blk = 4'h0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            load = 1'b0;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== exp_out(k, m_e)) begin
                    errors++;
                    $display("FAIL load_mid k=%0d e=%0d got=%h want=%h", k, m_e, act[k], exp_out(k, m_e));
                end
            end
            if (fd_a && !seen) begin
                seen = 1'b1;
                checks++;
                if (seg_a !== 7'h0E) begin
                    errors++;
                    $display("FAIL load_mid_F got=%h want=0e", seg_a);
                end
            end
        end
    endtask

    task automatic test_lz();
        load = 1'b1; val = 16'h0040; blk = 4'h0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            load = 1'b0;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== exp_out(k, m_e)) begin
                    errors++;
                    $display("FAIL lz k=%0d e=%0d got=%h want=%h", k, m_e, act[k], exp_out(k, m_e));
                end
            end
        end
    endtask

    task automatic test_wrap_load();
        int guard = 0;
        while ((m_e + 1) % 16 != 0 && guard < 32) begin @(negedge clk); guard++; end
        if (guard >= 32) begin
            errors++;
            $display("FAIL wrap_align timeout");
        end
        load = 1'b1; val = 16'h8888; blk = 4'h0;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if ({fd_a, seg_a, seg_b} !== {1'b1, 7'h00, 7'h00}) begin
            errors++;
            $display("FAIL wrap_load got=%b/%h/%h want=1/00/00", fd_a, seg_a, seg_b);
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== exp_out(k, m_e)) begin
                    errors++;
                    $display("FAIL wrap_frame k=%0d e=%0d got=%h want=%h", k, m_e, act[k], exp_out(k, m_e));
                end
            end
        end
    endtask

    task automatic test_dp();
        int lows = 0;
        load = 1'b1; val = 16'h5678; blk = 4'b0100; dp = 4'b0100;
        @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_e > 16 && !dpn_a) lows++;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== exp_out(k, m_e)) begin
                    errors++;
                    $display("FAIL dp k=%0d e=%0d got=%h want=%h", k, m_e, act[k], exp_out(k, m_e));
                end
            end
        end
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("FAIL dp_blanked got=%0d low cycles want=0", lows);
        end
        dp = 4'h0; blk = 4'h0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== exp_out(k, m_e)) begin
                    errors++;
                    $display("FAIL random k=%0d e=%0d got=%h want=%h", k, m_e, act[k], exp_out(k, m_e));
                end
            end
            load = ($urandom_range(0, 5) == 0);
            val  = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
            blk  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            dp   = 4'($urandom);
        end
        load = 1'b0;
    endtask

    task automatic test_rst_mid();
        int guard = 0;
        while ((m_e / 4) % 4 != 2 && guard < 32) begin @(negedge clk); guard++; end
        if (guard >= 32) begin
            errors++;
            $display("FAIL rst_align timeout");
        end
        load = 1'b1; val = 16'h3C3C;
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act[k] !== exp_out(k, 0)) begin
                errors++;
                $display("FAIL rst_mid k=%0d got=%h want=%h", k, act[k], exp_out(k, 0));
            end
        end
        @(negedge clk);
        load = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== exp_out(k, m_e)) begin
                    errors++;
                    $display("FAIL rst_restart k=%0d e=%0d got=%h want=%h", k, m_e, act[k], exp_out(k, m_e));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_mid();
        test_lz();
        test_wrap_load();
        test_dp();
        test_random();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
